imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 104 ++++++++++
 tb/tb_imem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction memory responder: fixed-latency fetch pipeline over a word array,
// with a backdoor load port, flush of in-flight fetches and a saturating kill counter.
module imem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        rsp_valid,
  output logic [31:0] rsp_addr,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        busy,
  output logic [15:0] kill_count
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] err_q;
  logic [31:0]        addr_q [LATENCY];
  logic [31:0]        data_q [LATENCY];

  logic [29:0] req_idx;
  logic [29:0] ld_idx;
  logic        req_in_range;
  logic        ld_in_range;
  logic        accept;
  logic [31:0] rd_data;
  logic        out_live;
  logic [3:0]  n_valid;
  logic [16:0] kill_sum;
  logic        unused_addr_bits;

  assign req_idx      = req_addr[31:2];
  assign ld_idx       = load_addr[31:2];
  assign req_in_range = ({2'b00, req_idx} < 32'(DEPTH_WORDS));
  assign ld_in_range  = ({2'b00, ld_idx} < 32'(DEPTH_WORDS));
  assign unused_addr_bits = ^{req_addr[1:0], load_addr[1:0]};

  // Loads win over fetches; the ready signal stays live through reset.
  assign req_ready = !load_en;
  assign accept    = req_valid && req_ready && !rst;
  assign rd_data   = req_in_range ? mem[req_idx[AW-1:0]] : 32'h0000_0000;

  always_ff @(posedge clk) begin
    if (load_en && !rst && ld_in_range) begin
      mem[ld_idx[AW-1:0]] <= load_data;
    end
  end

  always_comb begin
    n_valid = '0;
    for (int i = 0; i < LATENCY; i++) begin
      n_valid = n_valid + {3'b000, vld_q[i]};
    end
    kill_sum = {1'b0, kill_count} + {13'b0, n_valid};
  end

  // Stage 0 captures the word on the accept edge, so later loads cannot reach it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      err_q      <= '0;
      kill_count <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= accept;
      err_q[0]  <= accept && !req_in_range;
      addr_q[0] <= accept ? {req_addr[31:2], 2'b00} : 32'h0000_0000;
      data_q[0] <= accept ? rd_data : 32'h0000_0000;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1] && !flush;
        err_q[i]  <= err_q[i-1];
        addr_q[i] <= addr_q[i-1];
        data_q[i] <= data_q[i-1];
      end
      if (flush) begin
        kill_count <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
      end
    end
  end

  // An entry sitting in the output stage during a flush is counted as killed, so it is hidden.
  assign out_live  = vld_q[LATENCY-1] && !flush && !rst;
  assign rsp_valid = out_live;
  assign rsp_addr  = out_live ? addr_q[LATENCY-1] : 32'h0000_0000;
  assign rsp_data  = out_live ? data_q[LATENCY-1] : 32'h0000_0000;
  assign rsp_err   = out_live && err_q[LATENCY-1];
  assign busy      = |vld_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (LATENCY 2 and 3) share stimulus and are
// checked every cycle against an accept-history model, plus directed scenario checks.
module tb_imem_responder;

  localparam int N = 4096;

  logic        clk = 1'b0;
  logic        rst, req_valid, flush, load_en;
  logic [31:0] req_addr, load_addr, load_data;

  logic        req_ready2, rsp_valid2, rsp_err2, busy2;
  logic [31:0] rsp_addr2, rsp_data2;
  logic [15:0] kc2;
  logic        req_ready3, rsp_valid3, rsp_err3, busy3;
  logic [31:0] rsp_addr3, rsp_data3;
  logic [15:0] kc3;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready2),
    .flush(flush), .rsp_valid(rsp_valid2), .rsp_addr(rsp_addr2), .rsp_data(rsp_data2),
    .rsp_err(rsp_err2), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(busy2), .kill_count(kc2));

  imem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready3),
    .flush(flush), .rsp_valid(rsp_valid3), .rsp_addr(rsp_addr3), .rsp_data(rsp_data3),
    .rsp_err(rsp_err3), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(busy3), .kill_count(kc3));

  // Model: history of accepted requests and of cycles that kill the pipeline.
  bit          acc_v [N];
  logic [31:0] acc_a [N];
  logic [31:0] acc_d [N];
  bit          acc_e [N];
  bit          kill_h [N];
  logic [31:0] mmem [64];
  int          exp_kc [2];
  int          n;
  int          total, bad;

  // Observation logs for directed checks.
  bit          lv [2][N];
  bit          le [2][N];
  bit          lb [2][N];
  logic [31:0] la [2][N];
  logic [31:0] ld [2][N];
  logic [15:0] lk [2][N];
  bit          lrdy [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d obs=%h exp=%h", tag, n, obs, exp);
    end
  endtask

  // Accept at cycle a survives through cycle upto if no flush/reset hit it in (a, upto].
  function automatic bit alive(int a, int upto);
    if (a < 0 || !acc_v[a]) return 1'b0;
    for (int f = a + 1; f <= upto; f++) if (kill_h[f]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step(input bit rv, input logic [31:0] ra, input bit fl, input bit le_i,
                      input logic [31:0] la_i, input logic [31:0] ld_i, input bit r);
    int L, cnt;
    bit ev, eb;
    logic [31:0] idx, ea, ed;
    logic ov, oe, orr, ob;
    logic [31:0] oa, od;
    logic [15:0] okc;
    req_valid = rv; req_addr = ra; flush = fl; load_en = le_i;
    load_addr = la_i; load_data = ld_i; rst = r;
    kill_h[n] = fl | r;
    #1;
    for (int k = 0; k < 2; k++) begin
      L = k + 2;
      ev = alive(n - L, n);
      eb = 1'b0;
      for (int a = n - L; a < n; a++) if (alive(a, n - 1)) eb = 1'b1;
      ea = ev ? acc_a[n-L] : 32'h0;
      ed = ev ? acc_d[n-L] : 32'h0;
      if (k == 0) begin
        ov = rsp_valid2; oa = rsp_addr2; od = rsp_data2; oe = rsp_err2;
        orr = req_ready2; ob = busy2; okc = kc2;
      end else begin
        ov = rsp_valid3; oa = rsp_addr3; od = rsp_data3; oe = rsp_err3;
        orr = req_ready3; ob = busy3; okc = kc3;
      end
      chk($sformatf("rsp_valid_L%0d", L), {31'b0, ov}, {31'b0, ev});
      chk($sformatf("rsp_addr_L%0d", L), oa, ea);
      chk($sformatf("rsp_data_L%0d", L), od, ed);
      chk($sformatf("rsp_err_L%0d", L), {31'b0, oe}, {31'b0, ev && acc_e[n-L]});
      chk($sformatf("req_ready_L%0d", L), {31'b0, orr}, {31'b0, !le_i});
      chk($sformatf("busy_L%0d", L), {31'b0, ob}, {31'b0, eb});
      chk($sformatf("kill_count_L%0d", L), {16'b0, okc}, exp_kc[k]);
      lv[k][n] = ov; la[k][n] = oa; ld[k][n] = od; le[k][n] = oe; lb[k][n] = ob; lk[k][n] = okc;
    end
    lrdy[n] = req_ready2;
    for (int k = 0; k < 2; k++) begin
      L = k + 2;
      if (r) exp_kc[k] = 0;
      else if (fl) begin
        cnt = 0;
        for (int a = n - L; a < n; a++) if (alive(a, n - 1)) cnt++;
        exp_kc[k] = (exp_kc[k] + cnt > 65535) ? 65535 : exp_kc[k] + cnt;
      end
    end
    idx = {2'b00, ra[31:2]};
    acc_v[n] = rv && !le_i && !r;
    acc_a[n] = {ra[31:2], 2'b00};
    acc_e[n] = (idx >= 1024);
    acc_d[n] = (idx < 1024) ? mmem[idx[5:0]] : 32'h0;
    if (le_i && !r) begin
      idx = {2'b00, la_i[31:2]};
      if (idx < 64) mmem[idx[5:0]] = ld_i;
    end
    @(negedge clk);
    n++;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 4) != 0) a = ({26'b0, 6'($urandom_range(0, 63))} << 2) | ($urandom & 32'h3);
    else if ($urandom_range(0, 5) == 0) a = 32'hFFFF_FFFC;
    else begin
      a = $urandom;
      if (a[31:2] < 30'd1024) a = a | 32'h8000_0000;
    end
    return a;
  endfunction

  initial begin
    int s;
    int d;
    total = 0; bad = 0;
    exp_kc[0] = 0; exp_kc[1] = 0;
    for (int i = 0; i < N; i++) begin
      acc_v[i] = 1'b0; kill_h[i] = (i < 8);
    end
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; load_en = 1'b0;
    req_addr = '0; load_addr = '0; load_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n = 8;

    for (int i = 0; i < 64; i++) step(0, 0, 0, 1, 32'(i * 4), $urandom, 0);
    // Out-of-range load must not alias onto word 0.
    step(0, 0, 0, 1, 32'h0000_1000, 32'hBAD0_BAD0, 0);

    // Streaming at LATENCY 2.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'(i * 4), 32'(8'h11 * (i + 1)), 0);
    s = n;
    for (int i = 0; i < 4; i++) step(1, 32'(i * 4), 0, 0, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 4; i++) begin
      chk("stream_valid", {31'b0, lv[0][s+2+i]}, 32'd1);
      chk("stream_data", ld[0][s+2+i], 32'(8'h11 * (i + 1)));
      chk("stream_addr", la[0][s+2+i], 32'(i * 4));
    end
    chk("stream_tail", {31'b0, lv[0][s+6]}, 32'd0);

    // Flush at LATENCY 3.
    s = n;
    step(1, 32'h0, 0, 0, 0, 0, 0);
    step(1, 32'h4, 0, 0, 0, 0, 0);
    step(1, 32'h40, 1, 0, 0, 0, 0);
    idle(5);
    chk("flush_no_rsp0", {31'b0, lv[1][s+3]}, 32'd0);
    chk("flush_no_rsp4", {31'b0, lv[1][s+4]}, 32'd0);
    d = int'(lk[1][s+3]) - int'(lk[1][s+2]);
    chk("flush_kill_delta", d, 32'd2);
    chk("flush_new_valid", {31'b0, lv[1][s+5]}, 32'd1);
    chk("flush_new_addr", la[1][s+5], 32'h40);

    // Out-of-range addresses.
    s = n;
    step(1, 32'h0000_1000, 0, 0, 0, 0, 0);
    step(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    idle(3);
    chk("bad_valid", {31'b0, lv[0][s+2]}, 32'd1);
    chk("bad_err", {31'b0, le[0][s+2]}, 32'd1);
    chk("bad_data", ld[0][s+2], 32'h0);
    chk("bad_addr", la[0][s+2], 32'h0000_1000);
    chk("wrap_err", {31'b0, le[0][s+3]}, 32'd1);
    chk("wrap_addr", la[0][s+3], 32'hFFFF_FFFC);

    // Load priority over fetch.
    s = n;
    step(1, 32'h10, 0, 1, 32'h10, 32'hDEAD_BEEF, 0);
    step(1, 32'h10, 0, 0, 0, 0, 0);
    idle(3);
    chk("prio_ready", {31'b0, lrdy[s]}, 32'd0);
    chk("prio_no_rsp", {31'b0, lv[0][s+2]}, 32'd0);
    chk("prio_new_data", ld[0][s+3], 32'hDEAD_BEEF);

    // Load after accept keeps the captured word.
    step(0, 0, 0, 1, 32'h8, 32'h0000_AAAA, 0);
    s = n;
    step(1, 32'h8, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h8, 32'h0000_BBBB, 0);
    idle(3);
    chk("lda_data_L2", ld[0][s+2], 32'h0000_AAAA);
    chk("lda_data_L3", ld[1][s+3], 32'h0000_AAAA);

    // Reset with requests in flight; inputs during reset are ignored.
    s = n;
    step(1, 32'h0, 0, 0, 0, 0, 0);
    step(1, 32'h4, 0, 0, 0, 0, 0);
    step(1, 32'h8, 1, 1, 32'h0, 32'h5555_5555, 1);
    idle(4);
    step(1, 32'h0, 0, 0, 0, 0, 0);
    idle(3);
    for (int i = 3; i < 7; i++) begin
      chk("rst_no_rsp_L2", {31'b0, lv[0][s+i]}, 32'd0);
      chk("rst_no_rsp_L3", {31'b0, lv[1][s+i]}, 32'd0);
    end
    chk("rst_busy", {31'b0, lb[1][s+3]}, 32'd0);
    chk("rst_kill_count", {16'b0, lk[1][s+3]}, 32'd0);
    chk("rst_mem_kept", ld[0][s+9], 32'h0000_0011);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 9) == 0,
           $urandom_range(0, 7) == 0, rand_addr(), $urandom, $urandom_range(0, 59) == 0);
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
